// File: rtl/reg_bank_stream_reader.sv
// rtl/reg_bank_stream_reader.sv - register bank with sequential valid/ready burst reader
// Optional: define READ_PARITY_EN to add the registered out_parity output.
module reg_bank_stream_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      count,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef READ_PARITY_EN
  output logic             out_parity,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;
  logic [AW:0]      remaining;
  logic             load_first;
  logic             advance;
  logic [AW-1:0]    addr_inc;

  assign addr_inc = addr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            load_first = 1'b1;
            state_nxt  = STREAM;
          end else begin
            state_nxt  = FIN;
          end
        end
      end
      STREAM: begin
        // out_valid is high for the whole STREAM state, so out_ready alone marks a transfer
        if (out_ready) begin
          if (remaining > (AW+1)'(1)) advance = 1'b1;
          else                        state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign done      = (state == FIN);

  // Loads read pre-edge memory contents, so a same-edge write to the loaded address returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      out_data  <= '0;
      addr      <= '0;
      remaining <= '0;
`ifdef READ_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (load_first) begin
        addr      <= start_addr;
        remaining <= count;
        out_data  <= mem[start_addr];
`ifdef READ_PARITY_EN
        out_parity <= ^mem[start_addr];
`endif
      end else if (advance) begin
        addr      <= addr_inc;
        remaining <= remaining - (AW+1)'(1);
        out_data  <= mem[addr_inc];
`ifdef READ_PARITY_EN
        out_parity <= ^mem[addr_inc];
`endif
      end
    end
  end

endmodule
